// File: rtl/copy_task_responder_pkg.sv
// Shared definitions for the Copy task responder: state encoding, default
// widths and the flag bit that enables the additive operand.
package copy_task_responder_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 64;
    localparam int ADD_EN     = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCEPT = 2'b01,
        RUN    = 2'b11,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/copy_task_responder_stream_out_reg.sv
// One-entry registered output stage: loads on an input beat, clears on a
// lone output beat, holds under backpressure, and decides input readiness.
module stream_out_reg
    import copy_task_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_room,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_in_ready
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_load;

    // A new word may enter only when the slot is empty or draining this cycle.
    assign o_in_ready = i_run && i_room && (!r_valid || i_out_ready);
    assign w_load     = i_valid && o_in_ready;

    // Output slot: reload has priority so a simultaneous beat keeps valid high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= {DATA_W{1'b0}};
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/copy_task_responder.sv
// ap_ctrl child responder: accepts a start, latches chan/flags/n, copies n
// stream words (optionally adding chan) and reports ready/done/idle.
module copy_task_responder
    import copy_task_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_ready,
    output logic              ap_done,
    output logic              ap_idle,
    input  logic [63:0]       chan,
    input  logic [63:0]       flags,
    input  logic [CNT_W-1:0]  n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [DATA_W-1:0] r_chan;
    logic              r_add_en;

    logic              w_run;
    logic              w_room;
    logic              w_in_beat;
    logic              w_out_beat;
    logic              w_last_out;
    logic [DATA_W-1:0] w_word;
    logic              w_unused_flags;

    assign w_unused_flags = ^flags[63:1];

    assign w_run      = (r_state == RUN);
    assign w_room     = (r_in_cnt < r_n);
    assign w_in_beat  = in_valid && in_ready;
    assign w_out_beat = out_valid && out_ready;
    assign w_last_out = w_out_beat && (r_out_cnt == (r_n - CNT_W'(1)));
    assign w_word     = r_add_en ? (in_data + r_chan) : in_data;

    stream_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .i_clk       (ap_clk),
        .i_rst       (ap_rst),
        .i_run       (w_run),
        .i_room      (w_room),
        .i_data      (w_word),
        .i_valid     (in_valid),
        .i_out_ready (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_in_ready  (in_ready)
    );

    // State register, scalar capture at acceptance, and beat counters.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= IDLE;
            r_n       <= {CNT_W{1'b0}};
            r_in_cnt  <= {CNT_W{1'b0}};
            r_out_cnt <= {CNT_W{1'b0}};
            r_chan    <= {DATA_W{1'b0}};
            r_add_en  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_n       <= n;
                        r_chan    <= chan[DATA_W-1:0];
                        r_add_en  <= flags[ADD_EN];
                        r_in_cnt  <= {CNT_W{1'b0}};
                        r_out_cnt <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    if (w_in_beat) begin
                        r_in_cnt <= r_in_cnt + CNT_W'(1);
                    end
                    if (w_out_beat) begin
                        r_out_cnt <= r_out_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and handshake outputs, all decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_nxt = ACCEPT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCEPT: begin
                ap_ready = 1'b1;
                if (r_n == {CNT_W{1'b0}}) begin
                    ap_done     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last_out) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_copy_task_responder.sv
// Directed bench for copy_task_responder: a queue-based word model checked
// every cycle, plus literal timing and count expectations per scenario.
module tb_copy_task_responder;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic [63:0] chan;
    logic [63:0] flags;
    logic [63:0] n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 ap_clk = ~ap_clk;

    copy_task_responder dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_ready  (ap_ready),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .chan      (chan),
        .flags     (flags),
        .n         (n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int n_in = 0;
    int n_out = 0;
    int n_rdy = 0;
    int n_done = 0;
    int last_out_cyc = -1;
    logic [63:0] src_q[$];
    logic [63:0] exp_q[$];

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [63:0] w, input logic [63:0] c,
                                               input logic [63:0] f);
        return f[0] ? (w + c) : w;
    endfunction

    task automatic load_word(input logic [63:0] w, input logic [63:0] c, input logic [63:0] f);
        src_q.push_back(w);
        exp_q.push_back(model_word(w, c, f));
    endtask

    // which: 0 = ap_ready, 1 = ap_done
    task automatic wait_evt(input int which, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge ap_clk);
            if ((which == 0 && ap_ready) || (which == 1 && ap_done)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic start_run(input logic [63:0] c, input logic [63:0] f, input logic [63:0] nn,
                             input string name, output int t);
        int at;
        @(posedge ap_clk);
        #1;
        chan = c;
        flags = f;
        n = nn;
        ap_start = 1'b1;
        t = cyc;
        wait_evt(0, 20, name, at);
        ap_start = 1'b0;
        check({name, "_ready_lat"}, 64'(at - t), 64'd1);
    endtask

    // Stream driver and per-cycle comparison against the word model.
    initial begin
        bit fi;
        bit fo;
        bit stall_prev;
        logic [63:0] held;
        fi = 1'b0;
        stall_prev = 1'b0;
        held = 64'd0;
        in_valid = 1'b0;
        in_data = 64'd0;
        out_ready = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst) begin
                fi = in_valid && in_ready;
                fo = out_valid && out_ready;
                if (fo) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_out: got %0h expected no word", out_data);
                    end else begin
                        check("out_word", out_data, exp_q.pop_front());
                    end
                    n_out++;
                    last_out_cyc = cyc;
                end
                if (stall_prev) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", out_data, held);
                end
                if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
                if (ap_idle) begin
                    check("idle_in_ready", 64'(in_ready), 64'd0);
                    check("idle_out_valid", 64'(out_valid), 64'd0);
                end
                stall_prev = out_valid && !out_ready;
                held = out_data;
                if (fi) n_in++;
                if (ap_ready) n_rdy++;
                if (ap_done) n_done++;
            end else begin
                fi = 1'b0;
                stall_prev = 1'b0;
            end
            @(posedge ap_clk);
            #1;
            if (fi && src_q.size() > 0) void'(src_q.pop_front());
            in_valid = (src_q.size() > 0);
            in_data = in_valid ? src_q[0] : 64'd0;
            out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int at;
        int b_in;
        int b_out;
        int b_rdy;
        int b_done;
        int mid_out;
        ap_rst = 1'b1;
        ap_start = 1'b0;
        chan = 64'd0;
        flags = 64'd0;
        n = 64'd0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_ready", 64'(ap_ready), 64'd0);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // n = 0: ready and done together, idle again the cycle after
        @(posedge ap_clk);
        #1;
        chan = 64'd5;
        flags = 64'd1;
        n = 64'd0;
        ap_start = 1'b1;
        t = cyc;
        @(negedge ap_clk);
        check("n0_ready_t", 64'(ap_ready), 64'd0);
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("n0_ready", 64'(ap_ready), 64'd1);
        check("n0_done", 64'(ap_done), 64'd1);
        check("n0_in_ready", 64'(in_ready), 64'd0);
        check("n0_out_valid", 64'(out_valid), 64'd0);
        check("n0_not_idle", 64'(ap_idle), 64'd0);
        @(negedge ap_clk);
        check("n0_idle_back", 64'(ap_idle), 64'd1);
        check("n0_done_pulse", 64'(ap_done), 64'd0);

        // n = 4, plain copy, full throughput
        for (int i = 1; i <= 4; i++) load_word(64'(i), 64'h77, 64'd0);
        b_in = n_in;
        b_out = n_out;
        start_run(64'h77, 64'd0, 64'd4, "n4", t);
        wait_evt(1, 50, "n4_done", at);
        check("n4_done_cyc", 64'(at - t), 64'd7);
        @(negedge ap_clk);
        check("n4_idle_cyc", 64'(ap_idle), 64'd1);
        check("n4_words_out", 64'(n_out - b_out), 64'd4);
        check("n4_words_in", 64'(n_in - b_in), 64'd4);

        // n = 3, add with wrap; scalars changed after acceptance must not matter
        src_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        src_q.push_back(64'h1);
        src_q.push_back(64'h2);
        src_q.push_back(64'hAA);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'h11);
        exp_q.push_back(64'h12);
        b_in = n_in;
        start_run(64'h10, 64'd1, 64'd3, "wrap", t);
        chan = 64'hFFFF;
        flags = 64'd0;
        n = 64'd9;
        wait_evt(1, 50, "wrap_done", at);
        @(negedge ap_clk);
        check("wrap_words_in", 64'(n_in - b_in), 64'd3);
        check("wrap_left_in_src", 64'(src_q.size()), 64'd1);
        check("wrap_in_ready_after", 64'(in_ready), 64'd0);
        src_q.delete();

        // n = 5 with out_ready pattern 1,0,0 repeating
        for (int i = 0; i < 5; i++) load_word(64'(10 + i), 64'd3, 64'd1);
        b_out = n_out;
        rdy_mode = 1;
        start_run(64'd3, 64'd1, 64'd5, "bp", t);
        wait_evt(1, 100, "bp_done", at);
        check("bp_done_after_last", 64'(at - last_out_cyc), 64'd1);
        check("bp_words_out", 64'(n_out - b_out), 64'd5);
        check("bp_exp_drained", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;

        // reset in the middle of an n = 8 run
        for (int i = 0; i < 8; i++) load_word(64'(256 + i), 64'd0, 64'd0);
        b_out = n_out;
        start_run(64'd0, 64'd0, 64'd8, "rst", t);
        for (int i = 0; i < 40 && (n_out - b_out) < 2; i++) begin
            @(negedge ap_clk);
            #1;
        end
        check("rst_reached_two", 64'(n_out - b_out), 64'd2);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge ap_clk);
        check("mid_rst_idle", 64'(ap_idle), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_ready", 64'(ap_ready), 64'd0);
        load_word(64'h55, 64'd0, 64'd0);
        b_out = n_out;
        start_run(64'd0, 64'd0, 64'd1, "fresh", t);
        wait_evt(1, 30, "fresh_done", at);
        check("fresh_done_cyc", 64'(at - t), 64'd4);
        check("fresh_words_out", 64'(n_out - b_out), 64'd1);

        // back-to-back runs n = 2 then n = 3, restart asserted right after done
        for (int i = 0; i < 5; i++) load_word(64'(512 + i), 64'd1, 64'd1);
        @(negedge ap_clk);
        #1;
        b_out = n_out;
        b_rdy = n_rdy;
        b_done = n_done;
        start_run(64'd1, 64'd1, 64'd2, "b2b1", t);
        n = 64'd3;
        wait_evt(1, 50, "b2b1_done", at);
        ap_start = 1'b1;
        #1;
        mid_out = n_out;
        wait_evt(0, 20, "b2b2_ready", at);
        ap_start = 1'b0;
        wait_evt(1, 50, "b2b2_done", at);
        #1;
        check("b2b_ready_pulses", 64'(n_rdy - b_rdy), 64'd2);
        check("b2b_done_pulses", 64'(n_done - b_done), 64'd2);
        check("b2b_run1_words", 64'(mid_out - b_out), 64'd2);
        check("b2b_run2_words", 64'(n_out - mid_out), 64'd3);

        repeat (3) @(negedge ap_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/copy_task_responder.md
# copy_task_responder

Child-side responder for the ap_ctrl start/ready/done/idle handshake driven by the task-level control FSM toward each Copy task. It accepts a start request, latches the scalar arguments (chan, flags, n), and streams n words from an input stream to an output stream, optionally adding chan to each word. It then reports completion back to the initiator. One instance sits behind each Copy_k control port group of the bandwidth top.

## Interface
Parameters:
- DATA_W, 64, stream word width.
- CNT_W, 64, width of word count n and internal counters.

Ports:
- Clock and reset: one clock, `ap_clk`; reset `ap_rst` is synchronous and active-high.
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  start request; initiator holds it high until it sees ap_ready.
- ap_ready  out  1  one-cycle pulse: scalars consumed, new start may be issued.
- ap_done  out  1  one-cycle pulse: all n words delivered.
- ap_idle  out  1  high only in IDLE.
- chan  in  64  scalar; low DATA_W bits are the additive operand.
- flags  in  64  scalar; bit0 = add enable, other bits ignored.
- n  in  CNT_W  scalar; number of words to copy.
- in_data  in  DATA_W  input stream payload.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input stream ready.
- out_data  out  DATA_W  output stream payload (registered).
- out_valid  out  1  output stream valid (registered).
- out_ready  in  1  output stream ready.

## Operation
- States: IDLE, ACCEPT, RUN, DONE.
- IDLE: ap_idle=1. When ap_start=1 at the clock edge, latch chan/flags/n, clear in_cnt and out_cnt, and go to ACCEPT.
- ACCEPT: ap_ready=1 for exactly one cycle. ap_start is ignored.
  - If latched n==0: ap_done=1 in the same cycle, and the next state is IDLE.
  - Otherwise the next state is RUN.
- RUN:
  - in_ready = (in_cnt < n) && (!out_valid || out_ready).
  - An input beat (in_valid && in_ready) loads out_data with in_data + chan[DATA_W-1:0] if flags[0], else in_data. The add wraps modulo 2^DATA_W. The same beat sets out_valid and increments in_cnt.
  - An output beat (out_valid && out_ready) without a simultaneous input beat clears out_valid.
  - Each output beat increments out_cnt.
  - The output beat with out_cnt == n-1 moves the FSM to DONE.
- DONE: ap_done=1 for one cycle, then IDLE.
- ap_start high in DONE, or still high in the IDLE cycle after DONE, is a new request and is accepted normally from IDLE.
- in_ready=0 in every state except RUN. out_valid is never high outside RUN.
- Reset, including mid-operation, forces IDLE and drops any held output word:
  - ap_ready=0, ap_done=0, ap_idle=1.
  - in_ready=0, out_valid=0, out_data=0.
  - in_cnt=0, out_cnt=0.
- Scalar inputs are only sampled at acceptance. Later changes have no effect on the run in progress.

## Timing
- Start to ap_ready: ap_start sampled in cycle t (IDLE); ap_ready is high in cycle t+1.
- n==0: ap_ready and ap_done are both high in cycle t+1; ap_idle is high again in t+2.
- Earliest RUN cycle is t+2.
- Datapath latency: an input beat in cycle c makes the word visible on out_data/out_valid in cycle c+1.
- Throughput: 1 word/cycle with in_valid and out_ready held high.
- For n≥1 with no stalls:
  - last input beat at t+1+n;
  - last output beat at t+2+n;
  - ap_done at t+3+n;
  - ap_idle at t+4+n.
- Backpressure: with out_valid=1 and out_ready=0, out_data and out_valid hold and in_ready=0.
- Simultaneous input and output beat: the register reloads and out_valid stays 1.
- ap_idle is a registered state decode, so no combinational path exists from ap_start to any output.

## Structure
- Shared package entries:
  - state encoding constants: IDLE=2'b00, ACCEPT=2'b01, RUN=2'b11, DONE=2'b10;
  - DATA_W and CNT_W defaults;
  - flag bit index ADD_EN=0.
- One sub-module, `stream_out_reg`: the one-entry registered output stage with load/hold/clear and an in_ready computation.
- The FSM and counters live in the top.

## Test plan
- n=0, ap_start pulsed once: ap_ready=1 and ap_done=1 in the same cycle (t+1); no in_ready, no out_valid; ap_idle back at t+2.
- n=4, flags=0, inputs 1,2,3,4, out_ready=1: outputs 1,2,3,4 on consecutive cycles; ap_done exactly at t+7.
- n=3, flags=1, chan=0x10, inputs 0xFFFFFFFFFFFFFFF8,1,2: outputs 0x8,0x11,0x12 (wrap); exactly 3 input beats consumed; in_ready low afterwards.
- n=5 with out_ready toggling 1,0,0,1…: out_data stable while stalled; no word lost or duplicated; ap_done one cycle after the 5th output beat.
- ap_rst asserted mid-run at out_cnt=2 of n=8: next cycle ap_idle=1, out_valid=0, in_ready=0; a fresh ap_start with n=1 completes normally.
- Initiator model holds ap_start high until ap_ready, then re-asserts it immediately after ap_done for back-to-back runs (n=2, then n=3): exactly 2 ap_ready and 2 ap_done pulses; word counts 2 and 3.
